// File: rtl/dz_pkg.sv
// Shared definitions for the countdown controller and the display driver.
package dz_pkg;

    // Width of the countdown digit consumed by the 8x8 display driver.
    localparam int unsigned NUM_W = 3;

    // Default reload value of the countdown digit.
    localparam int unsigned START_VAL_DEFAULT = 5;

    // Countdown controller states.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } dz_state_e;

endpackage

// File: rtl/dz_key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle press pulse issued the cycle after the debounced level rises.
module dz_key_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic press_p
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             prev_q;
    logic             pulse_q;
    logic             pulse_d;

    // Synchronizer, debounce state and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= level_q;
            pulse_q <= pulse_d;
        end
    end

    // Count consecutive differing samples; accept the new level on the
    // sample that brings the count to DEBOUNCE_CYC.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        pulse_d = level_q & ~prev_q;
    end

    assign press_p = pulse_q;

endmodule

// File: rtl/dz_count_ctrl.sv
// Countdown controller for the dot-matrix display: debounced start/pause
// keys drive a START_VAL..0 countdown stepping once every TICK_DIV clocks.
module dz_count_ctrl
    import dz_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CYC = 20,
    parameter int unsigned START_VAL    = START_VAL_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_start,
    input  logic             key_pause,
    output logic [NUM_W-1:0] num,
    output logic             running,
    output logic             done
);

    localparam int unsigned PRESC_W = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [NUM_W-1:0]   NUM_START  = NUM_W'(START_VAL);
    localparam logic [NUM_W-1:0]   NUM_ONE    = NUM_W'(1);

    logic               start_p;
    logic               pause_p;
    dz_state_e          state_q;
    dz_state_e          state_d;
    logic [NUM_W-1:0]   num_q;
    logic [NUM_W-1:0]   num_d;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic               running_q;
    logic               running_d;
    logic               done_q;
    logic               done_d;
    logic               tick;
    logic               last_step;

    dz_key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_start_key (
        .clk    (clk),
        .rst    (rst),
        .key_raw(key_start),
        .press_p(start_p)
    );

    dz_key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_pause_key (
        .clk    (clk),
        .rst    (rst),
        .key_raw(key_pause),
        .press_p(pause_p)
    );

    assign tick      = (state_q == RUN) && (presc_q == PRESC_LAST);
    assign last_step = (num_q <= NUM_ONE);

    // State, count, prescaler and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            num_q     <= NUM_START;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    // Next-state selection; pause takes priority over a coincident tick.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_p) state_d = RUN;
            RUN: begin
                if (pause_p) begin
                    state_d = PAUSE;
                end else if (tick && last_step) begin
                    state_d = DONE;
                end
            end
            PAUSE:   if (start_p || pause_p) state_d = RUN;
            DONE:    if (start_p) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Count, prescaler and flag updates for the current state.
    always_comb begin
        num_d     = num_q;
        presc_d   = presc_q;
        done_d    = 1'b0;
        running_d = (state_d == RUN);
        unique case (state_q)
            IDLE: begin
                num_d = NUM_START;
                if (start_p) presc_d = '0;
            end
            RUN: begin
                // The prescaler advances on every RUN cycle, including the one
                // that takes the pause, so the held phase already includes it.
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick && !pause_p) begin
                    if (last_step) begin
                        num_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        num_d = num_q - 1'b1;
                    end
                end
            end
            PAUSE: begin
                num_d   = num_q;
                presc_d = presc_q;
            end
            DONE: begin
                num_d = '0;
                if (start_p) begin
                    num_d   = NUM_START;
                    presc_d = '0;
                end
            end
            default: begin
                num_d   = NUM_START;
                presc_d = '0;
            end
        endcase
    end

    assign num     = num_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_dz_count_ctrl.sv
// Directed bench for dz_count_ctrl with TICK_DIV=10, DEBOUNCE_CYC=4,
// START_VAL=5. A key press is acted on 8 edges after it is applied.
module tb_dz_count_ctrl;

    logic       clk;
    logic       rst;
    logic       ks;
    logic       kp;
    logic [2:0] num;
    logic       running;
    logic       done;

    int unsigned n_cmp;
    int unsigned n_err;
    int unsigned n_done;
    logic        done_prev;

    typedef struct {
        logic        ks;
        logic        kp;
        int unsigned ncyc;
        logic [2:0]  num;
        logic        run;
        logic        dn;
        string       name;
    } vec_t;

    vec_t tbl[13];

    dz_count_ctrl #(
        .TICK_DIV    (10),
        .DEBOUNCE_CYC(4),
        .START_VAL   (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_start(ks),
        .key_pause(kp),
        .num      (num),
        .running  (running),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [2:0] en,
                       input logic er, input logic ed);
        n_cmp++;
        if (num !== en || running !== er || done !== ed) begin
            n_err++;
            $display("FAIL %s: got num=%0d running=%0b done=%0b, want num=%0d running=%0b done=%0b",
                     name, num, running, done, en, er, ed);
        end
    endtask

    // done must be a single-cycle pulse.
    initial done_prev = 1'b0;
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            n_cmp++;
            if (done_prev !== 1'b0) begin
                n_err++;
                $display("FAIL done_width: got done high two cycles in a row, want single pulse");
            end
        end
        done_prev = done;
    end

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        n_done = 0;

        tbl[0]  = '{1'b1, 1'b0, 7,  3'd5, 1'b0, 1'b0, "press_wait"};
        tbl[1]  = '{1'b1, 1'b0, 1,  3'd5, 1'b1, 1'b0, "run_entry"};
        tbl[2]  = '{1'b1, 1'b0, 9,  3'd5, 1'b1, 1'b0, "pre_tick1"};
        tbl[3]  = '{1'b1, 1'b0, 1,  3'd4, 1'b1, 1'b0, "tick1"};
        tbl[4]  = '{1'b1, 1'b0, 2,  3'd4, 1'b1, 1'b0, "held20"};
        tbl[5]  = '{1'b0, 1'b0, 7,  3'd4, 1'b1, 1'b0, "pre_tick2"};
        tbl[6]  = '{1'b0, 1'b0, 1,  3'd3, 1'b1, 1'b0, "tick2"};
        tbl[7]  = '{1'b0, 1'b0, 10, 3'd2, 1'b1, 1'b0, "tick3"};
        tbl[8]  = '{1'b0, 1'b0, 10, 3'd1, 1'b1, 1'b0, "tick4"};
        tbl[9]  = '{1'b0, 1'b0, 9,  3'd1, 1'b1, 1'b0, "pre_last"};
        tbl[10] = '{1'b0, 1'b0, 1,  3'd0, 1'b0, 1'b1, "done_pulse"};
        tbl[11] = '{1'b0, 1'b0, 1,  3'd0, 1'b0, 1'b0, "done_clear"};
        tbl[12] = '{1'b0, 1'b0, 20, 3'd0, 1'b0, 1'b0, "done_hold"};

        rst = 1'b1;
        ks  = 1'b0;
        kp  = 1'b0;
        step(3);
        chk("reset", 3'd5, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            chk("idle", 3'd5, 1'b0, 1'b0);
        end

        // Pause in IDLE is ignored.
        kp = 1'b1;
        step(8);
        chk("pause_idle", 3'd5, 1'b0, 1'b0);
        kp = 1'b0;
        step(10);
        chk("pause_idle_after", 3'd5, 1'b0, 1'b0);

        // A 3-cycle glitch is shorter than the debounce window.
        ks = 1'b1;
        step(3);
        ks = 1'b0;
        step(20);
        chk("glitch", 3'd5, 1'b0, 1'b0);

        // Bounce 1-0-1-0 with 2-cycle phases, then stable high.
        ks = 1'b1; step(2);
        ks = 1'b0; step(2);
        ks = 1'b1; step(2);
        ks = 1'b0; step(2);
        ks = 1'b1;
        step(7);
        chk("bounce_wait", 3'd5, 1'b0, 1'b0);
        step(1);
        chk("bounce_start", 3'd5, 1'b1, 1'b0);
        ks = 1'b0;
        step(10);
        chk("bounce_tick1", 3'd4, 1'b1, 1'b0);
        step(10);
        chk("bounce_tick2", 3'd3, 1'b1, 1'b0);
        step(5);

        // Asynchronous reset between clock edges at num=3.
        #2 rst = 1'b1;
        #1 chk("async_reset", 3'd5, 1'b0, 1'b0);
        step(2);
        chk("reset_held", 3'd5, 1'b0, 1'b0);
        rst = 1'b0;
        step(10);
        chk("post_reset_idle", 3'd5, 1'b0, 1'b0);

        // Clean start held 20 cycles; full countdown to DONE.
        for (int i = 0; i < 13; i++) begin
            ks = tbl[i].ks;
            kp = tbl[i].kp;
            step(tbl[i].ncyc);
            chk(tbl[i].name, tbl[i].num, tbl[i].run, tbl[i].dn);
        end

        // Pause in DONE is ignored.
        kp = 1'b1;
        step(8);
        chk("pause_done", 3'd0, 1'b0, 1'b0);
        kp = 1'b0;
        step(10);
        chk("pause_done_after", 3'd0, 1'b0, 1'b0);

        // Start in DONE reloads and runs.
        ks = 1'b1;
        step(7);
        chk("done_wait", 3'd0, 1'b0, 1'b0);
        step(1);
        chk("reload", 3'd5, 1'b1, 1'b0);
        ks = 1'b0;
        step(9);
        chk("reload_pre_tick", 3'd5, 1'b1, 1'b0);
        kp = 1'b1;
        step(1);
        chk("reload_tick", 3'd4, 1'b1, 1'b0);
        step(6);
        chk("presc6", 3'd4, 1'b1, 1'b0);
        step(1);
        chk("pause_enter", 3'd4, 1'b0, 1'b0);
        kp = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            chk("pause_hold", 3'd4, 1'b0, 1'b0);
        end

        // Resume: held prescaler phase gives a decrement 3 cycles later.
        ks = 1'b1;
        step(8);
        chk("resume", 3'd4, 1'b1, 1'b0);
        ks = 1'b0;
        step(2);
        chk("resume_plus2", 3'd4, 1'b1, 1'b0);
        step(1);
        chk("resume_plus3", 3'd3, 1'b1, 1'b0);

        // Start press during RUN is ignored; pause lands on the tick at num=2.
        step(5);
        ks = 1'b1;
        step(7);
        chk("pre_ignore", 3'd2, 1'b1, 1'b0);
        kp = 1'b1;
        step(1);
        chk("start_ignored", 3'd2, 1'b1, 1'b0);
        ks = 1'b0;
        step(6);
        chk("pre_pause_tick", 3'd2, 1'b1, 1'b0);
        step(1);
        chk("pause_on_tick", 3'd2, 1'b0, 1'b0);
        kp = 1'b0;
        step(10);
        chk("pause_tick_hold", 3'd2, 1'b0, 1'b0);

        // Resume from a wrapped prescaler and finish the count.
        ks = 1'b1;
        step(8);
        chk("resume2", 3'd2, 1'b1, 1'b0);
        ks = 1'b0;
        step(9);
        chk("resume2_pre", 3'd2, 1'b1, 1'b0);
        step(1);
        chk("resume2_tick", 3'd1, 1'b1, 1'b0);
        step(9);
        chk("pre_done2", 3'd1, 1'b1, 1'b0);
        step(1);
        chk("done2", 3'd0, 1'b0, 1'b1);
        step(1);
        chk("done2_clear", 3'd0, 1'b0, 1'b0);
        step(5);

        n_cmp++;
        if (n_done != 2) begin
            n_err++;
            $display("FAIL done_count: got %0d pulses, want 2", n_done);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dz_count_ctrl.md
Name: dz_count_ctrl

Overview:
- Countdown source for the 8x8 dot-matrix display driver; produces the 3-bit digit `num` that the display block consumes.
- Debounces two raw push-buttons (start, pause) and runs a START_VAL..0 countdown at one step per TICK_DIV clocks.
- Flags completion so the display/colour logic and any buzzer can react.

Parameters:
- TICK_DIV, 1000, clk cycles per countdown step (1 s at 1 kHz); must be >= 2.
- DEBOUNCE_CYC, 20, consecutive stable synchronized samples required to accept a key level change; must be >= 1.
- START_VAL, 5, reload value of num; range 1..7.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- key_start  in  1  raw start/resume button, active-high, asynchronous to clk.
- key_pause  in  1  raw pause button, active-high, asynchronous to clk.
- num  out  3  current countdown value, registered; feeds the display driver.
- running  out  1  high while in RUN, registered.
- done  out  1  one-cycle pulse on the clock edge where num becomes 0.

Behaviour:
- Reset (asynchronous, any time, including mid-count or mid-debounce):
  - num=START_VAL, running=0, done=0, state=IDLE, prescaler=0.
  - Synchronizers and debounced levels = 0; debounce counters = 0.
- Key path, per key:
  - 2-flop synchronizer.
  - Debounce counter increments while the synchronized value differs from the debounced level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYC, the debounced level takes the synchronized value.
  - A press pulse (1 cycle) is emitted the cycle after the debounced level rises 0->1. No pulse on release.
  - Bounces shorter than DEBOUNCE_CYC produce no pulse.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - tick = (state==RUN && presc==TICK_DIV-1); presc wraps to 0 on tick.
  - Held, not cleared, in PAUSE. Cleared on entry to RUN from IDLE or DONE.
- State machine; all transitions on the edge where the pulse is high, outputs registered:
  - IDLE: num=START_VAL. start_p -> RUN. pause_p is ignored.
  - RUN:
    - pause_p -> PAUSE. If pause_p coincides with tick, pause wins and num does not decrement.
    - tick with num>1 -> num-1, stay in RUN.
    - tick with num==1 -> num=0, done=1 for that cycle, go to DONE.
    - start_p is ignored.
  - PAUSE: num and presc hold. start_p or pause_p -> RUN, resuming presc from its held value. Both together -> RUN.
  - DONE: num=0 holds. start_p -> reload num=START_VAL, presc=0, go to RUN. pause_p is ignored.
- running = (next state == RUN), registered with the state.
- Timing and invariants:
  - First decrement occurs exactly TICK_DIV cycles after the edge that entered RUN.
  - num never wraps below 0; no arithmetic underflow path exists.
  - done is never high in two consecutive cycles.

Decomposition:
- Shared package dz_pkg holds:
  - state enum {IDLE, RUN, PAUSE, DONE};
  - NUM_W=3;
  - default START_VAL.
- The display driver imports NUM_W from the same package.
- Sub-module dz_key_debounce (synchronizer + debounce counter + rising-edge pulse, parameter DEBOUNCE_CYC) is instantiated twice.

Test Plan (bench uses TICK_DIV=10, DEBOUNCE_CYC=4, START_VAL=5):
- Reset then idle 50 cycles -> num=5, running=0, done=0 throughout; assert rst mid-run at num=3 -> next sample num=5, running=0, asynchronously.
- Clean key_start held 20 cycles -> running rises 2+4+1+1 cycles after press; num steps 5,4,3,2,1,0 at 10-cycle intervals; done pulses exactly once when num becomes 0; state DONE, running=0.
- key_start bouncing 1-0-1 with 2-cycle highs, then stable -> exactly one start pulse; glitch-only stimulus (3-cycle high) -> no pulse, num stays 5.
- During RUN at num=4 with presc=6, press pause -> num holds 4 for 100 cycles; press start -> next decrement to 3 exactly 3 cycles after resume.
- Pause pulse forced on the tick cycle at num=2 -> num stays 2, state PAUSE; a start press in RUN -> ignored, count continues.
- In DONE, press start -> num=5 next cycle, running=1, first decrement 10 cycles later; pause in IDLE/DONE -> no change.
